// File: rtl/dram_req_scheduler_pkg.sv
// Shared types and address-map constants for the two-port DRAM request scheduler.
package dram_sched_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    PRE_WAIT,
    ACT,
    ACT_WAIT,
    RD_CMD,
    RD_WAIT,
    WR_CMD,
    WR_WAIT,
    RESP
  } state_t;

  localparam int ROW_MSB = 22;
  localparam int ROW_LSB = 12;
  localparam int COL_MSB = 11;
  localparam int COL_LSB = 2;
  localparam logic [3:0] WEN_NONE = 4'hF;

  // A wait state lasting (t-1) cycles counts down from t-2 to zero.
  function automatic logic [2:0] wait_load(input int t);
    return 3'(t - 2);
  endfunction

endpackage

// File: rtl/dram_req_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter: ptr names the preferred port, output is one-hot.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req[ptr]) begin
      gnt[ptr] = 1'b1;
    end else if (req[~ptr]) begin
      gnt[~ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/dram_req_scheduler.sv
// Shares one DRAM pin interface between two single-beat requesters with
// round-robin arbitration, open-row tracking and PRE/ACT/RD/WR sequencing.
module dram_req_scheduler
  import dram_sched_pkg::*;
#(
  parameter int T_RP  = 5,
  parameter int T_RCD = 4,
  parameter int T_WR  = 2
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_wdata,
  input  logic [1:0][3:0] req_web,
  output logic [1:0]      rsp_valid,
  output logic [31:0]     rsp_rdata,
  input  logic [31:0]     Q,
  input  logic            VALID,
  output logic            CSn,
  output logic            RASn,
  output logic            CASn,
  output logic [3:0]      WEn,
  output logic [10:0]     A,
  output logic [31:0]     D
);

  localparam logic [2:0] RP_LOAD  = wait_load(T_RP);
  localparam logic [2:0] RCD_LOAD = wait_load(T_RCD);
  localparam logic [2:0] WR_LOAD  = wait_load(T_WR);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        row_open_reg, row_open_next;
  logic [10:0] open_row_reg, open_row_next;
  logic        rr_ptr_reg, rr_ptr_next;
  logic        gnt_reg;
  logic [10:0] row_reg;
  logic [9:0]  col_reg;
  logic        we_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  web_reg;
  logic [31:0] rdata_reg, rdata_next;

  logic [1:0]  gnt;
  logic        sel;
  logic        accept;
  logic [10:0] sel_row;
  state_t      cmd_state;
  logic        unused_addr;

  rr_arbiter2 u_arb (
    .req (req_valid),
    .ptr (rr_ptr_reg),
    .gnt (gnt)
  );

  assign sel       = gnt[1];
  assign accept    = (state_reg == IDLE) && (|req_valid);
  assign sel_row   = req_addr[sel][ROW_MSB:ROW_LSB];
  assign cmd_state = we_reg ? WR_CMD : RD_CMD;
  assign CSn       = 1'b0;
  assign rsp_rdata = rdata_reg;
  assign unused_addr = ^{req_addr[0][31:ROW_MSB+1], req_addr[0][COL_LSB-1:0],
                         req_addr[1][31:ROW_MSB+1], req_addr[1][COL_LSB-1:0]};

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign rsp_valid[gi] = (state_reg == RESP) && (gnt_reg == 1'(gi));
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    row_open_next = row_open_reg;
    open_row_next = open_row_reg;
    rr_ptr_next   = rr_ptr_reg;
    rdata_next    = rdata_reg;
    req_ready     = '0;
    RASn          = 1'b1;
    CASn          = 1'b1;
    WEn           = WEN_NONE;
    A             = '0;
    D             = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          req_ready = gnt;
          if (row_open_reg && (sel_row == open_row_reg)) begin
            state_next = req_we[sel] ? WR_CMD : RD_CMD;
          end else if (row_open_reg) begin
            state_next = PRE;
          end else begin
            state_next = ACT;
          end
        end
      end
      PRE: begin
        RASn          = 1'b0;
        WEn           = 4'h0;
        A             = open_row_reg;
        row_open_next = 1'b0;
        if (T_RP > 1) begin
          state_next = PRE_WAIT;
          cnt_next   = RP_LOAD;
        end else begin
          state_next = ACT;
        end
      end
      PRE_WAIT: begin
        if (cnt_reg == 3'd0) state_next = ACT;
        else                 cnt_next   = cnt_reg - 3'd1;
      end
      ACT: begin
        RASn          = 1'b0;
        A             = row_reg;
        row_open_next = 1'b1;
        open_row_next = row_reg;
        if (T_RCD > 1) begin
          state_next = ACT_WAIT;
          cnt_next   = RCD_LOAD;
        end else begin
          state_next = cmd_state;
        end
      end
      ACT_WAIT: begin
        if (cnt_reg == 3'd0) state_next = cmd_state;
        else                 cnt_next   = cnt_reg - 3'd1;
      end
      RD_CMD: begin
        CASn       = 1'b0;
        A          = {1'b0, col_reg};
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        // No timeout: the device is trusted to eventually return data.
        if (VALID) begin
          rdata_next = Q;
          state_next = RESP;
        end
      end
      WR_CMD: begin
        CASn = 1'b0;
        WEn  = web_reg;
        D    = wdata_reg;
        A    = {1'b0, col_reg};
        if (T_WR > 1) begin
          state_next = WR_WAIT;
          cnt_next   = WR_LOAD;
        end else begin
          state_next = RESP;
        end
      end
      WR_WAIT: begin
        if (cnt_reg == 3'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 3'd1;
      end
      RESP: begin
        rr_ptr_next = ~gnt_reg;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      row_open_reg <= 1'b0;
      open_row_reg <= '0;
      rr_ptr_reg   <= 1'b0;
      gnt_reg      <= 1'b0;
      row_reg      <= '0;
      col_reg      <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      web_reg      <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      row_open_reg <= row_open_next;
      open_row_reg <= open_row_next;
      rr_ptr_reg   <= rr_ptr_next;
      rdata_reg    <= rdata_next;
      if (accept) begin
        gnt_reg   <= sel;
        row_reg   <= sel_row;
        col_reg   <= req_addr[sel][COL_MSB:COL_LSB];
        we_reg    <= req_we[sel];
        wdata_reg <= req_wdata[sel];
        web_reg   <= req_web[sel];
      end
    end
  end

endmodule
